// File: rtl/logic_alu_sequencer.sv
// logic_alu_sequencer: latches one logic/shift request behind a valid/ready
// handshake, executes it (shifts iteratively, one bit per clock) and holds the
// registered result with zero/err flags until the consumer acknowledges it.
module logic_alu_sequencer #(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    op,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  result,
  output logic          zero,
  output logic          err,
  output logic          busy,
  output logic [CW-1:0] done_count
);

  localparam int unsigned    CNTW   = $clog2(N + 1);
  localparam logic [N-1:0]   N_OPND = N'(N);
  localparam logic [CNTW-1:0] N_CNT = CNTW'(N);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SHIFT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [N-1:0]    b_q, b_d;
  logic [N-1:0]    acc_q, acc_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    result_q, result_d;
  logic            zero_q, zero_d;
  logic            err_q, err_d;
  logic [CW-1:0]   count_q, count_d;
  logic [N-1:0]    logic_res;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (in_valid) state_d = (op[2:1] == 2'b10) ? S_SHIFT : S_EXEC;
      S_EXEC:  state_d = S_DONE;
      S_SHIFT: if (cnt_q == '0) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state only
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
  end

  // Bitwise unit; acc_q carries operand A for both logic ops and shifts
  always_comb begin
    logic_res = '0;
    case (op_q)
      OP_AND:  logic_res = acc_q & b_q;
      OP_OR:   logic_res = acc_q | b_q;
      OP_XOR:  logic_res = acc_q ^ b_q;
      OP_NOT:  logic_res = ~acc_q;
      default: logic_res = '0;
    endcase
  end

  // Datapath next-state: request latch, execute/shift step, completion count
  always_comb begin
    op_d     = op_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
    count_d  = count_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d  = op;
          b_d   = b;
          acc_d = a;
          // shift count saturates at N: anything larger clears all bits anyway
          cnt_d = (b >= N_OPND) ? N_CNT : CNTW'(b);
        end
      end
      S_EXEC: begin
        result_d = logic_res;
        zero_d   = (logic_res == '0);
        err_d    = (op_q[2:1] == 2'b11);
      end
      S_SHIFT: begin
        if (cnt_q == '0) begin
          result_d = acc_q;
          zero_d   = (acc_q == '0);
          err_d    = 1'b0;
        end else begin
          acc_d = op_q[0] ? {acc_q[N-2:0], 1'b0} : {1'b0, acc_q[N-1:1]};
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) count_d = count_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      op_q     <= op_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      count_q  <= count_d;
    end
  end

  assign result     = result_q;
  assign zero       = zero_q;
  assign err        = err_q;
  assign done_count = count_q;

endmodule
